// File: rtl/winograd_output_transform.sv
// Winograd F(4,3) output transform: Y = A^T*M*A on a 6x6 product tile, exact
// division by 576 to undo the x24 kernel scaling, saturation to OUT_W, valid/ready output.
module winograd_output_transform #(
  parameter int IN_W  = 32,
  parameter int ACC_W = 44,
  parameter int OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  m_in [0:5][0:5],
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] y_out [0:3][0:3],
  output logic                    sat_flag,
  output logic [2:0]              state_dbg
);

  // Handshake: a transfer happens on a rising clk edge where valid && ready are
  // both high. Upstream holds m_in/in_valid until that edge; the block holds
  // y_out/sat_flag/out_valid until the out_valid && out_ready edge.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ROW  = 3'd1,
    S_COL  = 3'd2,
    S_DIV  = 3'd3,
    S_OUT  = 3'd4
  } state_t;

  // floor(a/9) for a < 2^DIV_W via a * ceil(2^K/9) >> K; error term 9m-2^K <= 8 keeps it exact
  localparam int DIV_W = ACC_W - 6;
  localparam int K     = DIV_W + 4;
  localparam int PW    = DIV_W + K + 1;
  localparam logic [K:0] RECIP = ({1'b1, {K{1'b0}}} + (K+1)'(8)) / (K+1)'(9);

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - ACC_W'(1);

  state_t                   state_q, state_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     sat_flag_q, sat_flag_d;
  logic                     sat_acc_q, sat_acc_d;
  logic [3:0]               idx_q, idx_d;
  logic signed [IN_W-1:0]   m_q     [0:5][0:5];
  logic signed [IN_W-1:0]   m_d     [0:5][0:5];
  logic signed [ACC_W-1:0]  t_q     [0:3][0:5];
  logic signed [ACC_W-1:0]  t_d     [0:3][0:5];
  logic signed [ACC_W-1:0]  y_acc_q [0:3][0:3];
  logic signed [ACC_W-1:0]  y_acc_d [0:3][0:3];
  logic signed [OUT_W-1:0]  y_out_q [0:3][0:3];
  logic signed [OUT_W-1:0]  y_out_d [0:3][0:3];

  logic signed [ACC_W-1:0]  q_v;
  logic signed [ACC_W-1:0]  q_sat_v;
  logic                     sat_v;

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [IN_W-1:0] v);
    return ACC_W'(v);
  endfunction

  // One row of A^T applied to a 6-vector, shifts and adds only
  function automatic logic signed [ACC_W-1:0] at_row(
    input logic [1:0]              r,
    input logic signed [ACC_W-1:0] v0, v1, v2, v3, v4, v5
  );
    logic signed [ACC_W-1:0] s12, d12, s34, d34;
    s12 = v1 + v2;
    d12 = v1 - v2;
    s34 = v3 + v4;
    d34 = v3 - v4;
    case (r)
      2'd0:    return v0 + s12 + s34;
      2'd1:    return d12 + (d34 <<< 1);
      2'd2:    return s12 + (s34 <<< 2);
      default: return d12 + (d34 <<< 3) + v5;
    endcase
  endfunction

  // Truncating division by 576 on the magnitude, sign restored afterwards
  function automatic logic signed [ACC_W-1:0] div576(input logic signed [ACC_W-1:0] y);
    logic [ACC_W-1:0] mag;
    logic [DIV_W-1:0] a;
    logic [PW-1:0]    prod;
    logic [ACC_W-1:0] q_mag;
    mag   = y[ACC_W-1] ? (~y + ACC_W'(1)) : y;
    a     = DIV_W'(mag >> 6);
    prod  = PW'(a) * PW'(RECIP);
    q_mag = ACC_W'(prod >> K);
    return y[ACC_W-1] ? -$signed(q_mag) : $signed(q_mag);
  endfunction

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    sat_flag_d  = sat_flag_q;
    sat_acc_d   = sat_acc_q;
    idx_d       = idx_q;
    m_d         = m_q;
    t_d         = t_q;
    y_acc_d     = y_acc_q;
    y_out_d     = y_out_q;
    q_v         = div576(y_acc_q[idx_q[3:2]][idx_q[1:0]]);
    q_sat_v     = q_v;
    sat_v       = 1'b0;

    case (state_q)
      S_IDLE: begin
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          m_d        = m_in;
          in_ready_d = 1'b0;
          state_d    = S_ROW;
        end
      end
      S_ROW: begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 6; c++) begin
            t_d[r][c] = at_row(2'(r), sext(m_q[0][c]), sext(m_q[1][c]), sext(m_q[2][c]),
                               sext(m_q[3][c]), sext(m_q[4][c]), sext(m_q[5][c]));
          end
        end
        state_d = S_COL;
      end
      S_COL: begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            y_acc_d[r][c] = at_row(2'(c), t_q[r][0], t_q[r][1], t_q[r][2],
                                   t_q[r][3], t_q[r][4], t_q[r][5]);
          end
        end
        idx_d      = 4'd0;
        sat_acc_d  = 1'b0;
        sat_flag_d = 1'b0;
        state_d    = S_DIV;
      end
      S_DIV: begin
        if (q_v > SAT_MAX) begin
          q_sat_v = SAT_MAX;
          sat_v   = 1'b1;
        end else if (q_v < SAT_MIN) begin
          q_sat_v = SAT_MIN;
          sat_v   = 1'b1;
        end
        y_out_d[idx_q[3:2]][idx_q[1:0]] = OUT_W'(q_sat_v);
        sat_acc_d = sat_acc_q | sat_v;
        if (idx_q == 4'd15) begin
          out_valid_d = 1'b1;
          sat_flag_d  = sat_acc_q | sat_v;
          state_d     = S_OUT;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      sat_acc_q   <= 1'b0;
      idx_q       <= 4'd0;
      m_q         <= '{default: '0};
      t_q         <= '{default: '0};
      y_acc_q     <= '{default: '0};
      y_out_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      sat_flag_q  <= sat_flag_d;
      sat_acc_q   <= sat_acc_d;
      idx_q       <= idx_d;
      m_q         <= m_d;
      t_q         <= t_d;
      y_acc_q     <= y_acc_d;
      y_out_q     <= y_out_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_flag_q;
  assign y_out     = y_out_q;
  assign state_dbg = state_q;

endmodule
